// File: rtl/i2c_reg_slave.sv
// I2C register target: pointer byte, multi-byte write/read with auto-increment,
// repeated START, NUM_OUT RW output bytes followed by NUM_IN RO input bytes.
module i2c_reg_slave #(
  parameter logic [6:0]  SLAVE_ADDR = 7'h57,
  parameter int unsigned NUM_OUT    = 2,
  parameter int unsigned NUM_IN     = 2,
  parameter logic [7:0]  OUT_RESET  = 8'h00
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  scl,
  inout  logic                  sda,
  input  logic [8*NUM_IN-1:0]   in_data,
  output logic [8*NUM_OUT-1:0]  out_data,
  output logic                  wr_strobe,
  output logic [2:0]            wr_index,
  output logic                  busy,
  output logic [3:0]            debug_state
);

  localparam int unsigned NREG = NUM_OUT + NUM_IN;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    RX_ADDR   = 4'd1,
    ADDR_ACK  = 4'd2,
    RX_PTR    = 4'd3,
    PTR_ACK   = 4'd4,
    RX_DATA   = 4'd5,
    DATA_ACK  = 4'd6,
    TX_DATA   = 4'd7,
    TX_ACK    = 4'd8,
    WAIT_STOP = 4'd9
  } state_t;

  state_t      state;
  logic [2:0]  scl_sync, sda_sync;
  logic [3:0]  bit_cnt;
  logic [7:0]  shreg;
  logic [3:0]  ptr;
  logic        rw;
  logic        ack_drv;
  logic        tx_load;
  logic        sda_oe, sda_o;

  logic        scl_rise, scl_fall, start_det, stop_det;
  logic [7:0]  rx_byte, rd_byte, ptr_wide;
  logic [3:0]  ptr_inc;

  assign scl_rise  = scl_sync[1] & ~scl_sync[2];
  assign scl_fall  = ~scl_sync[1] & scl_sync[2];
  assign start_det = scl_sync[1] & sda_sync[2] & ~sda_sync[1];
  assign stop_det  = scl_sync[1] & ~sda_sync[2] & sda_sync[1];
  assign rx_byte   = {shreg[6:0], sda_sync[1]};
  assign ptr_wide  = shreg % 8'(NREG);
  assign ptr_inc   = (ptr == 4'(NREG - 1)) ? '0 : ptr + 4'd1;

  assign sda         = sda_oe ? sda_o : 1'bz;
  assign debug_state = state;

  always_comb begin
    rd_byte = '0;
    for (int unsigned k = 0; k < NUM_OUT; k++)
      if (ptr == 4'(k)) rd_byte = out_data[8*k +: 8];
    for (int unsigned k = 0; k < NUM_IN; k++)
      if (ptr == 4'(NUM_OUT + k)) rd_byte = in_data[8*k +: 8];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      scl_sync  <= '1;
      sda_sync  <= '1;
      bit_cnt   <= '0;
      shreg     <= '0;
      ptr       <= '0;
      rw        <= 1'b0;
      ack_drv   <= 1'b0;
      tx_load   <= 1'b0;
      sda_oe    <= 1'b0;
      sda_o     <= 1'b1;
      out_data  <= {NUM_OUT{OUT_RESET}};
      wr_strobe <= 1'b0;
      wr_index  <= '0;
      busy      <= 1'b0;
    end else begin
      scl_sync  <= {scl_sync[1:0], scl};
      sda_sync  <= {sda_sync[1:0], sda};
      wr_strobe <= 1'b0;
      if (stop_det) begin
        state   <= IDLE;
        sda_oe  <= 1'b0;
        busy    <= 1'b0;
        ack_drv <= 1'b0;
        tx_load <= 1'b0;
      end else if (start_det) begin
        state   <= RX_ADDR;
        bit_cnt <= '0;
        sda_oe  <= 1'b0;
        ack_drv <= 1'b0;
        tx_load <= 1'b0;
      end else begin
        case (state)
          RX_ADDR, RX_PTR, RX_DATA: begin
            if (scl_rise) begin
              shreg   <= rx_byte;
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7) begin
                bit_cnt <= '0;
                if (state == RX_PTR) begin
                  state <= PTR_ACK;
                end else if (state == RX_DATA) begin
                  state <= DATA_ACK;
                end else if (rx_byte[7:1] == SLAVE_ADDR) begin
                  state <= ADDR_ACK;
                  rw    <= rx_byte[0];
                  busy  <= 1'b1;
                end else begin
                  state <= WAIT_STOP;
                  busy  <= 1'b0;
                end
              end
            end
          end
          ADDR_ACK, PTR_ACK, DATA_ACK: begin
            // first falling edge starts the ACK and commits; second one ends it
            if (scl_fall) begin
              if (!ack_drv) begin
                ack_drv <= 1'b1;
                sda_oe  <= 1'b1;
                sda_o   <= 1'b0;
                if (state == PTR_ACK) ptr <= ptr_wide[3:0];
                if (state == DATA_ACK) begin
                  for (int unsigned k = 0; k < NUM_OUT; k++) begin
                    if (ptr == 4'(k)) begin
                      out_data[8*k +: 8] <= shreg;
                      wr_strobe          <= 1'b1;
                      wr_index           <= ptr[2:0];
                    end
                  end
                  ptr <= ptr_inc;
                end
              end else begin
                ack_drv <= 1'b0;
                bit_cnt <= '0;
                if (state == ADDR_ACK && rw) begin
                  state <= TX_DATA;
                  shreg <= rd_byte;
                  sda_o <= rd_byte[7];
                end else begin
                  sda_oe <= 1'b0;
                  state  <= (state == ADDR_ACK) ? RX_PTR : RX_DATA;
                end
              end
            end
          end
          TX_DATA: begin
            if (scl_rise) begin
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall) begin
              if (tx_load) begin
                tx_load <= 1'b0;
                shreg   <= rd_byte;
                sda_o   <= rd_byte[7];
                sda_oe  <= 1'b1;
              end else if (bit_cnt == 4'd8) begin
                sda_oe <= 1'b0;
                state  <= TX_ACK;
              end else begin
                shreg <= {shreg[6:0], 1'b0};
                sda_o <= shreg[6];
              end
            end
          end
          TX_ACK: begin
            if (scl_rise) begin
              if (!sda_sync[1]) begin
                ptr     <= ptr_inc;
                state   <= TX_DATA;
                tx_load <= 1'b1;
                bit_cnt <= '0;
              end else begin
                state <= WAIT_STOP;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_reg_slave.sv
// Directed bench for i2c_reg_slave: bit-banged I2C master, write vector table
// plus hand-written read, mismatch, partial-byte and reset sequences.
`timescale 1ns/1ps
module tb_i2c_reg_slave;

  localparam int Q = 80;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        scl = 1'b1;
  logic        m_low = 1'b0;
  wire         sda;
  logic [15:0] in_data = 16'h8155;
  logic [15:0] out_data;
  logic        wr_strobe;
  logic [2:0]  wr_index;
  logic        busy;
  logic [3:0]  debug_state;

  int checks = 0;
  int failures = 0;

  logic [2:0] strobe_q[$];
  logic       slave_drove = 1'b0;
  logic       busy_seen = 1'b0;

  assign sda = m_low ? 1'b0 : 1'bz;
  pullup (sda);

  always #5 clk = ~clk;

  i2c_reg_slave #(
    .SLAVE_ADDR(7'h57),
    .NUM_OUT(2),
    .NUM_IN(2),
    .OUT_RESET(8'h00)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .scl(scl),
    .sda(sda),
    .in_data(in_data),
    .out_data(out_data),
    .wr_strobe(wr_strobe),
    .wr_index(wr_index),
    .busy(busy),
    .debug_state(debug_state)
  );

  always @(negedge clk) begin
    if (wr_strobe) strobe_q.push_back(wr_index);
    if (sda === 1'b0 && !m_low) slave_drove = 1'b1;
    if (busy) busy_seen = 1'b1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic i2c_start();
    m_low = 1'b0; scl = 1'b1; #Q;
    m_low = 1'b1; #Q;
    scl = 1'b0; #Q;
  endtask

  task automatic i2c_rstart();
    m_low = 1'b0; #Q;
    scl = 1'b1; #Q;
    m_low = 1'b1; #Q;
    scl = 1'b0; #Q;
  endtask

  task automatic i2c_stop();
    m_low = 1'b1; #Q;
    scl = 1'b1; #Q;
    m_low = 1'b0; #(2*Q);
  endtask

  task automatic write_bit(input logic b);
    m_low = ~b; #Q;
    scl = 1'b1; #(2*Q);
    scl = 1'b0; #20;
    m_low = 1'b0; #(Q-20);
  endtask

  task automatic read_bit(output logic b);
    m_low = 1'b0; #Q;
    scl = 1'b1; #Q;
    b = sda; #Q;
    scl = 1'b0; #Q;
  endtask

  task automatic write_byte(input logic [7:0] data, output logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) write_bit(data[i]);
    read_bit(b);
    ack = (b == 1'b0);
  endtask

  task automatic read_byte(output logic [7:0] data, input logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      data[i] = b;
    end
    write_bit(~ack);
  endtask

  typedef struct {
    logic [7:0]  ptr;
    logic [7:0]  data;
    logic [15:0] exp_out;
    int          exp_strobes;
    logic [2:0]  exp_idx;
  } wr_vec_t;

  wr_vec_t vecs[5];

  initial begin
    #2ms;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       ack;
    logic [7:0] rd;
    logic [7:0] exp_rd[4];

    vecs[0] = '{8'h00, 8'h5A, 16'h115A, 1, 3'd0};
    vecs[1] = '{8'h05, 8'h22, 16'h225A, 1, 3'd1};
    vecs[2] = '{8'h02, 8'hFF, 16'h225A, 0, 3'd0};
    vecs[3] = '{8'h0C, 8'h81, 16'h2281, 1, 3'd0};
    vecs[4] = '{8'h00, 8'h3C, 16'h223C, 1, 3'd0};
    exp_rd = '{8'h55, 8'h81, 8'h3C, 8'hA5};

    #50;
    check("rst_out_data", 32'(out_data), 32'h0);
    check("rst_wr_strobe", 32'(wr_strobe), 32'h0);
    check("rst_wr_index", 32'(wr_index), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_state", 32'(debug_state), 32'h0);
    check("rst_sda_released", 32'(sda), 32'h1);
    rst_n = 1'b1;
    #100;

    // two-byte write with auto-increment
    strobe_q.delete();
    i2c_start();
    write_byte(8'hAE, ack); check("t1_addr_ack", 32'(ack), 32'h1);
    check("t1_busy", 32'(busy), 32'h1);
    write_byte(8'h00, ack); check("t1_ptr_ack", 32'(ack), 32'h1);
    write_byte(8'h3C, ack); check("t1_d0_ack", 32'(ack), 32'h1);
    write_byte(8'hA5, ack); check("t1_d1_ack", 32'(ack), 32'h1);
    i2c_stop();
    check("t1_out_data", 32'(out_data), 32'hA53C);
    check("t1_strobes", 32'(strobe_q.size()), 32'd2);
    if (strobe_q.size() == 2) begin
      check("t1_idx0", 32'(strobe_q[0]), 32'd0);
      check("t1_idx1", 32'(strobe_q[1]), 32'd1);
    end
    check("t1_busy_after", 32'(busy), 32'h0);

    // pointer set then repeated-START read with wrap
    i2c_start();
    write_byte(8'hAE, ack); check("t2_addr_ack", 32'(ack), 32'h1);
    write_byte(8'h02, ack); check("t2_ptr_ack", 32'(ack), 32'h1);
    i2c_rstart();
    write_byte(8'hAF, ack); check("t2_raddr_ack", 32'(ack), 32'h1);
    for (int i = 0; i < 4; i++) begin
      read_byte(rd, i < 3);
      check($sformatf("t2_rd%0d", i), 32'(rd), 32'(exp_rd[i]));
    end
    check("t2_sda_released", 32'(sda), 32'h1);
    check("t2_wait_stop", 32'(debug_state), 32'd9);
    i2c_stop();
    check("t2_idle", 32'(debug_state), 32'd0);

    // foreign address: never driven, never busy
    slave_drove = 1'b0;
    busy_seen = 1'b0;
    i2c_start();
    write_byte(8'hA0, ack); check("t3_addr_nack", 32'(ack), 32'h0);
    write_byte(8'h00, ack);
    write_byte(8'h55, ack);
    i2c_stop();
    check("t3_sda_never_driven", 32'(slave_drove), 32'h0);
    check("t3_busy_never", 32'(busy_seen), 32'h0);
    check("t3_out_data", 32'(out_data), 32'hA53C);

    // write to RO register is discarded, pointer wraps to 0
    strobe_q.delete();
    i2c_start();
    write_byte(8'hAE, ack); check("t4_addr_ack", 32'(ack), 32'h1);
    write_byte(8'h03, ack); check("t4_ptr_ack", 32'(ack), 32'h1);
    write_byte(8'h77, ack); check("t4_data_ack", 32'(ack), 32'h1);
    i2c_stop();
    check("t4_out_data", 32'(out_data), 32'hA53C);
    check("t4_no_strobe", 32'(strobe_q.size()), 32'd0);
    i2c_start();
    write_byte(8'hAF, ack); check("t4_raddr_ack", 32'(ack), 32'h1);
    read_byte(rd, 1'b0);
    check("t4_ptr_wrapped", 32'(rd), 32'h3C);
    i2c_stop();

    // partial data byte aborted by STOP
    strobe_q.delete();
    i2c_start();
    write_byte(8'hAE, ack);
    write_byte(8'h00, ack);
    write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b0);
    i2c_stop();
    check("t5_out_data", 32'(out_data), 32'hA53C);
    check("t5_idle", 32'(debug_state), 32'd0);
    check("t5_no_strobe", 32'(strobe_q.size()), 32'd0);
    i2c_start();
    write_byte(8'hAE, ack); check("t5b_addr_ack", 32'(ack), 32'h1);
    write_byte(8'h01, ack);
    write_byte(8'h11, ack); check("t5b_data_ack", 32'(ack), 32'h1);
    i2c_stop();
    check("t5b_out_data", 32'(out_data), 32'h113C);
    check("t5b_strobes", 32'(strobe_q.size()), 32'd1);
    if (strobe_q.size() == 1) check("t5b_idx", 32'(strobe_q[0]), 32'd1);

    // single-byte write vectors
    for (int v = 0; v < 5; v++) begin
      strobe_q.delete();
      i2c_start();
      write_byte(8'hAE, ack); check($sformatf("v%0d_addr_ack", v), 32'(ack), 32'h1);
      write_byte(vecs[v].ptr, ack); check($sformatf("v%0d_ptr_ack", v), 32'(ack), 32'h1);
      write_byte(vecs[v].data, ack); check($sformatf("v%0d_data_ack", v), 32'(ack), 32'h1);
      i2c_stop();
      check($sformatf("v%0d_out_data", v), 32'(out_data), 32'(vecs[v].exp_out));
      check($sformatf("v%0d_strobes", v), 32'(strobe_q.size()), 32'(vecs[v].exp_strobes));
      if (vecs[v].exp_strobes > 0 && strobe_q.size() > 0)
        check($sformatf("v%0d_idx", v), 32'(strobe_q[0]), 32'(vecs[v].exp_idx));
    end

    // async reset while the slave drives a 0 data bit
    i2c_start();
    write_byte(8'hAE, ack);
    write_byte(8'h00, ack);
    i2c_rstart();
    write_byte(8'hAF, ack); check("t6_raddr_ack", 32'(ack), 32'h1);
    check("t6_sda_low", 32'(sda), 32'h0);
    check("t6_tx_state", 32'(debug_state), 32'd7);
    rst_n = 1'b0;
    #1;
    check("t6_sda_released", 32'(sda), 32'h1);
    check("t6_out_data", 32'(out_data), 32'h0);
    check("t6_idle", 32'(debug_state), 32'd0);
    check("t6_busy", 32'(busy), 32'h0);
    #50;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/i2c_reg_slave.md
Name: i2c_reg_slave

Overview:
Parametrised I2C target with a register pointer, multi-byte write and read, auto-increment, and repeated-START support.
- Exposes NUM_OUT writable output bytes (for example LED or control bytes) and NUM_IN read-only input bytes (for example switches or status).
- Sits on the shared board I2C bus next to the single-byte peripheral slaves.
- Runs on the 100 MHz system clock and oversamples SCL/SDA.

Parameters:
SLAVE_ADDR, 7'h57, 7-bit target address.
NUM_OUT, 2, number of RW output registers (1..8), mapped at pointer 0..NUM_OUT-1.
NUM_IN, 2, number of RO input registers (1..8), mapped at pointer NUM_OUT..NUM_OUT+NUM_IN-1.
OUT_RESET, 0, reset value of every output byte.

Ports:
clk  input  1  system clock, 100 MHz.
rst_n  input  1  asynchronous active-low reset.
scl  input  1  I2C clock from master.
sda  inout  1  I2C data; driven only to 0 or its bit value while sda_oe=1, else high-Z.
in_data  input  8*NUM_IN  input bytes; byte k is at [8k+7:8k].
out_data  output  8*NUM_OUT  output register bytes.
wr_strobe  output  1  one-clk pulse when an output byte is written.
wr_index  output  3  register index of the last write; valid with wr_strobe.
busy  output  1  high from address match to STOP or non-match.
debug_state  output  4  current FSM state encoding.

Behaviour:
- Reset (async, rst_n=0): everything below takes its reset value immediately.
  - State IDLE, sda high-Z.
  - out_data=OUT_RESET, wr_strobe=0, wr_index=0, busy=0, pointer=0.
  - SCL/SDA synchronisers preset to 1.
- Reset mid-transfer: sda is released within the same cycle (async). No partial write is committed.
- Sampling and edges:
  - scl and sda each pass through a 3-flop synchroniser.
  - Edges are detected from stages 2/1.
  - START = synchronised SDA falling while SCL high. STOP = synchronised SDA rising while SCL high.
- Bit timing:
  - Received bits are sampled on SCL rising.
  - Slave-driven bits (ACK and TX data) change on SCL falling, MSB first.
- Total registers: N = NUM_OUT+NUM_IN.
- Pointer rules:
  - Pointer width is 4 bits; it increments modulo N after every data byte, read or write.
  - A pointer byte with value >= N is ACKed and taken modulo N.
- FSM states: IDLE, RX_ADDR, ADDR_ACK, RX_PTR, PTR_ACK, RX_DATA, DATA_ACK, TX_DATA, TX_ACK, WAIT_STOP.
  - IDLE -> RX_ADDR on START.
  - RX_ADDR: shifts 8 bits. On the 8th rising edge, an address match goes to ADDR_ACK; a mismatch goes to WAIT_STOP and sda is never driven.
  - ADDR_ACK:
    - Drive 0 from the falling edge after bit 8 until the next falling edge.
    - Then go to RX_PTR if R/W=0.
    - If R/W=1, go to TX_DATA and place bit 7 of the register at the pointer on that same falling edge.
    - Read bytes are captured into the shift register when loaded. Input bytes come from in_data; output bytes are read back from out_data.
  - RX_PTR -> PTR_ACK: the pointer is loaded at the ACK falling edge. Then go to RX_DATA.
  - RX_DATA -> DATA_ACK, which always ACKs.
    - If the pointer < NUM_OUT, the byte is written at the ACK falling edge, with a wr_strobe pulse and wr_index=pointer.
    - If the pointer addresses an RO register, the write is discarded and there is no strobe.
    - The pointer then increments, and the FSM returns to RX_DATA.
  - TX_DATA: 8 bits, then TX_ACK (sda released).
    - At the 9th SCL rising, sampled SDA=0 (ACK): pointer++ and go to TX_DATA; the next byte's MSB is driven on the following falling edge.
    - SDA=1 (NACK): go to WAIT_STOP.
  - WAIT_STOP: sda released; waits only for STOP or START.
- START in any non-IDLE state (repeated START):
  - Go to RX_ADDR with the bit count cleared and sda released.
  - The pointer is retained, so [W ptr][Sr][R] reads from ptr.
- STOP in any state: go to IDLE, release sda, busy=0.
  - A byte in progress is dropped.
  - The pointer is retained.
- Simultaneous events: STOP/START detection has priority over SCL edge handling in the same cycle.
- Writes to out_data are never from a partial byte.

Test Plan:
- Write S,0xAE,0x00,0x3C,0xA5,P -> both ACKed; out_data=16'hA53C; two wr_strobe pulses with wr_index 0 then 1.
- Read, with in_data=16'h8155 and the pointer set to 2 via S,0xAE,0x02,Sr,0xAF: master ACKs 3 bytes then NACKs the 4th. Bytes returned are 0x55, 0x81, 0x3C, 0xA5 (pointer wraps 3->0->1); slave releases SDA after the NACK.
- Address 0x50 write (0xA0) -> no ACK, sda high-Z for the entire transfer, out_data unchanged, busy stays 0.
- Write S,0xAE,0x03,0x77,P -> ACKed; out_data unchanged; no wr_strobe; pointer=0 afterwards.
- Write S,0xAE,0x00 then 4 data bits, then STOP -> out_data unchanged, FSM IDLE. A following write of 0x11 to pointer 1 succeeds.
- Assert rst_n low during TX_DATA with SDA driven low -> sda high-Z immediately, out_data=0, debug_state=IDLE.
